// File: rtl/bus_pkg.sv
// Shared types and defaults for the system-bus arbiter.
// Watchdog logic is present only when BUS_ARBITER_WATCHDOG_EN is defined.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_GAP     = 2'd2
  } arb_state_t;

  localparam int BUS_DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/bus_watchdog.sv
// Bus access timeout: pulses watchdog for one cycle after TIMEOUT consecutive
// pending edges. Instantiated by bus_arbiter only under BUS_ARBITER_WATCHDOG_EN.
module bus_watchdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT = BUS_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_bus,
  input  logic wr_bus,
  input  logic fc_bus,
  output logic watchdog,
  output logic watchdog_fire
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic             w_pending;
  logic [CNT_W-1:0] r_count;
  logic             r_watchdog;

  assign w_pending = (rd_bus || wr_bus) && !fc_bus;

  // Combinational strike lets the arbiter revoke the grant on the same edge
  // that raises the registered pulse.
  assign watchdog_fire = w_pending && (r_count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_watchdog <= 1'b0;
    end else begin
      r_watchdog <= watchdog_fire;
      if (!w_pending || watchdog_fire) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign watchdog = r_watchdog;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter with a dead cycle between owners.
// Define BUS_ARBITER_WATCHDOG_EN to enable the access-timeout watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int TIMEOUT = BUS_DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] bus_req,
  output logic [MASTERS-1:0] bus_grant,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic               fc_bus,
  output logic               watchdog
);

  localparam int               IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(MASTERS - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_next;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_last_next;
  logic [MASTERS-1:0] r_grant;
  logic [MASTERS-1:0] w_grant_next;

  logic [IDX_W-1:0]   w_winner;
  logic [MASTERS-1:0] w_winner_onehot;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;
  logic               w_busy;
  logic               w_wd_fire;

  assign w_busy = rd_bus || wr_bus;

  // Scan last+1, last+2, ... modulo MASTERS; first requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      w_sum = {1'b0, r_last} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(MASTERS)) begin
        w_sum = w_sum - (IDX_W + 1)'(MASTERS);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && bus_req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_onehot
    assign w_winner_onehot[gi] = (w_winner == IDX_W'(gi));
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_grant_next = r_grant;
    case (r_state)
      ARB_IDLE: begin
        w_grant_next = '0;
        if (w_found) begin
          w_owner_next = w_winner;
          w_last_next  = w_winner;
          w_grant_next = w_winner_onehot;
          w_state_next = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        // A dropped request is honoured only once the bus is quiet.
        if ((!bus_req[r_owner] && !w_busy) || w_wd_fire) begin
          w_grant_next = '0;
          w_state_next = ARB_GAP;
        end
      end
      ARB_GAP: begin
        w_grant_next = '0;
        w_state_next = ARB_IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_last  <= LAST_INIT;
      r_grant <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_grant <= w_grant_next;
    end
  end

  assign bus_grant = r_grant;

`ifdef BUS_ARBITER_WATCHDOG_EN
  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .rd_bus       (rd_bus),
    .wr_bus       (wr_bus),
    .fc_bus       (fc_bus),
    .watchdog     (watchdog),
    .watchdog_fire(w_wd_fire)
  );
`else
  logic w_unused;
  assign w_unused  = fc_bus ^ (TIMEOUT < 2);
  assign w_wd_fire = 1'b0;
  assign watchdog  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter; expectations adapt to BUS_ARBITER_WATCHDOG_EN.
module tb_bus_arbiter;

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bus_req;
  logic [3:0] bus_grant;
  logic       rd_bus;
  logic       wr_bus;
  logic       fc_bus;
  logic       watchdog;

  typedef struct {
    logic [3:0] grant;
    logic       wd;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MASTERS(4),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_req  (bus_req),
    .bus_grant(bus_grant),
    .rd_bus   (rd_bus),
    .wr_bus   (wr_bus),
    .fc_bus   (fc_bus),
    .watchdog (watchdog)
  );

  function automatic logic [3:0] oh(input int m);
    logic [3:0] one;
    one = 4'b0001;
    return one << m;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] req, input logic rd, input logic wr,
                      input logic fc, input logic rs, input logic [3:0] eg,
                      input logic ew, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    bus_req = req;
    rd_bus  = rd;
    wr_bus  = wr;
    fc_bus  = fc;
    rst     = rs;
    e.grant = eg;
    e.wd    = ew;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare once per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus_grant !== e.grant || watchdog !== e.wd) begin
          errors++;
          $display("FAIL %s: got grant=%b wd=%b, expected grant=%b wd=%b",
                   e.name, bus_grant, watchdog, e.grant, e.wd);
        end else begin
          $display("ok   %s: grant=%b wd=%b", e.name, bus_grant, watchdog);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    bus_req = 4'b0000;
    rd_bus  = 1'b0;
    wr_bus  = 1'b0;
    fc_bus  = 1'b0;

    step(4'b0000, 0, 0, 0, 1, 4'b0000, 0, "reset0");
    step(4'b0000, 0, 0, 0, 1, 4'b0000, 0, "reset1");

    // Basic grant, drop, gap, re-grant
    step(4'b0110, 0, 0, 0, 0, 4'b0010, 0, "s1_grant1");
    step(4'b0110, 0, 0, 0, 0, 4'b0010, 0, "s1_hold");
    step(4'b0100, 0, 0, 0, 0, 4'b0000, 0, "s1_gap");
    step(4'b0100, 0, 0, 0, 0, 4'b0000, 0, "s1_idle");
    step(4'b0100, 0, 0, 0, 0, 4'b0100, 0, "s1_grant2");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s1_release");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s1_idle2");

    // Round robin with all masters requesting, pointer restored by reset
    step(4'b1111, 0, 0, 0, 1, 4'b0000, 0, "s2_reset");
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        step(4'b1111, 0, 0, 0, 0, oh(r % 4), 0, $sformatf("s2_own%0d_c%0d", r % 4, c));
      end
      step(4'b1111 & ~oh(r % 4), 0, 0, 0, 0, 4'b0000, 0, $sformatf("s2_gap%0d", r));
      step(4'b1111, 0, 0, 0, 0, 4'b0000, 0, $sformatf("s2_idle%0d", r));
    end

    // Request dropped while busy: grant held until the access ends
    step(4'b0010, 0, 0, 0, 0, 4'b0010, 0, "s3_grant");
    step(4'b0010, 1, 0, 0, 0, 4'b0010, 0, "s3_rd");
    step(4'b0000, 1, 0, 0, 0, 4'b0010, 0, "s3_drop_busy");
    step(4'b0000, 1, 0, 1, 0, 4'b0010, 0, "s3_fc");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s3_gap");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s3_idle");

    // Timeout while granted; revoked owner rejoins behind master 0
    step(4'b1000, 0, 0, 0, 0, 4'b1000, 0, "s4_grant");
    for (int i = 1; i <= 16; i++) begin
      step(4'b1000, 1, 0, 0, 0, (i == 16 && WD_EN) ? 4'b0000 : 4'b1000,
           (i == 16) && WD_EN, $sformatf("s4_pend%0d", i));
    end
    step(4'b1001, 1, 0, 0, 0, WD_EN ? 4'b0000 : 4'b1000, 0, "s4_after");
    step(4'b1001, 1, 0, 0, 0, WD_EN ? 4'b0001 : 4'b1000, 0, "s4_rejoin");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s4_release");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s4_idle");

    // fc_bus on the 16th pending edge wins; then an ungranted write times out
    for (int i = 1; i <= 16; i++) begin
      step(4'b0000, 1, 0, (i == 16), 0, 4'b0000, 0, $sformatf("s5_fc%0d", i));
    end
    for (int i = 1; i <= 16; i++) begin
      step(4'b0000, 0, 1, 0, 0, 4'b0000, (i == 16) && WD_EN, $sformatf("s5_wr%0d", i));
    end
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s5_end");

    // Reset mid-tenure clears grant, counter and pointer
    step(4'b0010, 0, 0, 0, 0, 4'b0010, 0, "s6_grant");
    for (int i = 1; i <= 3; i++) begin
      step(4'b0010, 1, 0, 0, 0, 4'b0010, 0, $sformatf("s6_pend%0d", i));
    end
    step(4'b0010, 1, 0, 0, 1, 4'b0000, 0, "s6_reset");
    for (int i = 1; i <= 15; i++) begin
      step(4'b1111, 1, 0, 0, 0, 4'b0001, 0, $sformatf("s6_post%0d", i));
    end
    step(4'b0000, 1, 0, 0, 0, WD_EN ? 4'b0000 : 4'b0001, WD_EN, "s6_drop_and_wd");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s6_gap");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, "s6_idle");

    repeat (2) @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
